// File: rtl/quad_decoder.sv
// quad_decoder: quadrature A/B decoder with glitch filter and loadable position counter.
// Define QUAD_DECODER_X4_EN for x4 decoding; otherwise only 10->00 / 00->10 count (x1).
module quad_decoder #(
    parameter int counter_size = 32,
    parameter int filter_len   = 3
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic                    enable,
    input  logic                    load,
    input  logic [counter_size-1:0] cnt_in,
    input  logic                    quad_a,
    input  logic                    quad_b,
    output logic                    step,
    output logic                    dir,
    output logic [counter_size-1:0] cnt_out,
    output logic                    overflow,
    output logic                    err
);
    localparam logic [3:0] FLT_LEN = 4'(filter_len);
    localparam logic [counter_size-1:0] ONE = counter_size'(1);

    logic [1:0] s1_q, s2_q, cand_q;
    logic [1:0] vld_q;
    logic [1:0] filt_q, filt_d;
    logic [3:0] fcnt_q, fcnt_d, run;
    logic init_q, init_d;
    logic step_q, step_d;
    logic dir_q, dir_d;
    logic ovf_q, ovf_d;
    logic err_q, err_d;
    logic [counter_size-1:0] cnt_q, cnt_d;
    logic accept, fwd, rev, dbl, cnt_up, cnt_dn;

    // vld_q blanks the filter until the synchroniser holds real pin samples
    always_ff @(posedge clk) begin
        if (res) begin
            s1_q   <= 2'b00;
            s2_q   <= 2'b00;
            cand_q <= 2'b00;
            vld_q  <= 2'b00;
            filt_q <= 2'b00;
            fcnt_q <= 4'd0;
            init_q <= 1'b1;
            step_q <= 1'b0;
            dir_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            s1_q   <= {quad_a, quad_b};
            s2_q   <= s1_q;
            cand_q <= s2_q;
            vld_q  <= {vld_q[0], 1'b1};
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            init_q <= init_d;
            step_q <= step_d;
            dir_q  <= dir_d;
            ovf_q  <= ovf_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        run    = (s2_q == cand_q) ? fcnt_q + 4'd1 : 4'd1;
        accept = 1'b0;
        fcnt_d = fcnt_q;
        if (!vld_q[1]) begin
            fcnt_d = 4'd0;
        end else if (!init_q && (s2_q == filt_q)) begin
            fcnt_d = 4'd0;
        end else if (run >= FLT_LEN) begin
            accept = 1'b1;
            fcnt_d = 4'd0;
        end else begin
            fcnt_d = run;
        end
    end

    // Position index along the forward sequence 00,01,11,10
    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        dbl = 1'b0;
        unique case ({filt_q, s2_q})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: fwd = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: rev = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: dbl = 1'b1;
            default: ;
        endcase
`ifdef QUAD_DECODER_X4_EN
        cnt_up = fwd;
        cnt_dn = rev;
`else
        cnt_up = fwd && (filt_q == 2'b10);
        cnt_dn = rev && (filt_q == 2'b00);
`endif
    end

    always_comb begin
        filt_d = filt_q;
        init_d = init_q;
        step_d = 1'b0;
        dir_d  = dir_q;
        ovf_d  = 1'b0;
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        if (accept) begin
            filt_d = s2_q;
            init_d = 1'b0;
            if (!init_q) begin
                err_d = dbl;
                if (enable && (cnt_up || cnt_dn)) begin
                    step_d = 1'b1;
                    dir_d  = cnt_dn;
                    if (cnt_up) begin
                        cnt_d = cnt_q + ONE;
                        ovf_d = &cnt_q;
                    end else begin
                        cnt_d = cnt_q - ONE;
                        ovf_d = ~|cnt_q;
                    end
                end
            end
        end
        if (load) begin
            cnt_d = cnt_in;
            ovf_d = 1'b0;
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign cnt_out  = cnt_q;
    assign overflow = ovf_q;
    assign err      = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// tb_quad_decoder: randomized self-checking bench for quad_decoder.
// Reference model tracks encoder position index arithmetic per held pin level.
module tb_quad_decoder;
    localparam int CW  = 32;
    localparam int FL  = 3;
    localparam int LAT = FL + 2;
`ifdef QUAD_DECODER_X4_EN
    localparam bit X4 = 1'b1;
`else
    localparam bit X4 = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          res;
    logic          enable;
    logic          load;
    logic [CW-1:0] cnt_in;
    logic          quad_a;
    logic          quad_b;
    logic          step;
    logic          dir;
    logic [CW-1:0] cnt_out;
    logic          overflow;
    logic          err;

    int checks   = 0;
    int failures = 0;

    logic [1:0]    m_lvl;
    logic [CW-1:0] m_cnt;
    logic          m_dir;
    int            idx_of[4] = '{0, 1, 3, 2};

    quad_decoder #(.counter_size(CW), .filter_len(FL)) dut (
        .clk(clk),
        .res(res),
        .enable(enable),
        .load(load),
        .cnt_in(cnt_in),
        .quad_a(quad_a),
        .quad_b(quad_b),
        .step(step),
        .dir(dir),
        .cnt_out(cnt_out),
        .overflow(overflow),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic [1:0] lvl, input int hold);
        int ns;
        int ne;
        int no;
        ns = 0;
        ne = 0;
        no = 0;
        @(negedge clk);
        res    = 1'b1;
        load   = 1'b0;
        quad_a = lvl[1];
        quad_b = lvl[0];
        @(posedge clk);
        #1;
        chk("rst_step", step, 0);
        chk("rst_dir", dir, 0);
        chk("rst_cnt", cnt_out, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        res = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (step) ns++;
            if (err) ne++;
            if (overflow) no++;
        end
        chk("init_step", ns, 0);
        chk("init_err", ne, 0);
        chk("init_ovf", no, 0);
        chk("init_cnt", cnt_out, 0);
        m_lvl = lvl;
        m_cnt = '0;
        m_dir = 1'b0;
    endtask

    // lmode: 0 no load, 1 load on first edge, 2 load on the capture edge
    task automatic segment(input logic [1:0] lvl, input int hold, input bit en,
                           input int lmode, input logic [CW-1:0] lval);
        int ns;
        int ne;
        int no;
        int fs;
        int fe;
        int d;
        bit up;
        bit dn;
        bit de;
        bit es;
        bit eo;
        ns = 0;
        ne = 0;
        no = 0;
        fs = 0;
        fe = 0;
        d  = (idx_of[lvl] - idx_of[m_lvl] + 4) % 4;
        up = X4 ? (d == 1) : (m_lvl == 2'b10 && lvl == 2'b00);
        dn = X4 ? (d == 3) : (m_lvl == 2'b00 && lvl == 2'b10);
        de = (d == 2);
        es = en && (up || dn);
        eo = 1'b0;
        if (lmode == 1) m_cnt = lval;
        if (es) begin
            m_dir = dn;
            if (up) begin
                eo    = (m_cnt == 32'hFFFF_FFFF);
                m_cnt = m_cnt + 32'd1;
            end else begin
                eo    = (m_cnt == 32'd0);
                m_cnt = m_cnt - 32'd1;
            end
        end
        if (lmode == 2) begin
            m_cnt = lval;
            eo    = 1'b0;
        end
        m_lvl = lvl;
        @(negedge clk);
        quad_a = lvl[1];
        quad_b = lvl[0];
        enable = en;
        cnt_in = lval;
        load   = (lmode == 1);
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk);
            #1;
            if (step) begin
                ns++;
                if (fs == 0) fs = k;
            end
            if (err) begin
                ne++;
                if (fe == 0) fe = k;
            end
            if (overflow) no++;
            load = (lmode == 2 && k == LAT - 1);
        end
        chk("step_n", ns, es);
        chk("err_n", ne, de);
        chk("ovf_n", no, eo);
        chk("cnt", cnt_out, m_cnt);
        chk("dir", dir, m_dir);
        if (es) chk("step_lat", fs, LAT);
        if (de) chk("err_lat", fe, LAT);
    endtask

    task automatic glitch(input bit on_a, input int g, input int hold);
        int np;
        np = 0;
        load = 1'b0;
        for (int k = 1; k <= hold; k++) begin
            @(negedge clk);
            if (on_a) quad_a = (k <= g) ? ~m_lvl[1] : m_lvl[1];
            else      quad_b = (k <= g) ? ~m_lvl[0] : m_lvl[0];
            @(posedge clk);
            #1;
            if (step || err || overflow) np++;
        end
        chk("glitch_pulse", np, 0);
        chk("glitch_cnt", cnt_out, m_cnt);
        chk("glitch_dir", dir, m_dir);
    endtask

    function automatic logic [CW-1:0] pick_val();
        case ($urandom_range(0, 3))
            0: return 32'hFFFF_FFFF;
            1: return 32'h0;
            2: return 32'hFFFF_FFFE;
            default: return 32'($urandom);
        endcase
    endfunction

    logic [1:0] fwd_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    initial begin
        res    = 1'b1;
        enable = 1'b1;
        load   = 1'b0;
        cnt_in = '0;
        quad_a = 1'b1;
        quad_b = 1'b1;
        m_lvl  = 2'b11;
        m_cnt  = '0;
        m_dir  = 1'b0;
        repeat (3) @(posedge clk);

        do_reset(2'b11, 20);
        do_reset(2'b00, 20);
        for (int i = 0; i < 4; i++) segment(fwd_seq[i], 10, 1'b1, 0, '0);

        segment(2'b01, 10, 1'b1, 1, 32'hFFFF_FFFE);
        for (int i = 1; i < 8; i++) segment(fwd_seq[i % 4], 10, 1'b1, 0, '0);
        segment(2'b10, 10, 1'b1, 0, '0);

        glitch(1'b1, 2, 12);
        glitch(1'b0, 1, 12);

        segment(2'b00, 10, 1'b1, 0, '0);
        segment(2'b11, 10, 1'b1, 0, '0);
        segment(2'b10, 10, 1'b0, 0, '0);
        segment(2'b00, 10, 1'b0, 0, '0);
        segment(2'b01, 10, 1'b0, 0, '0);

        segment(2'b00, 10, 1'b1, 2, 32'h1234_5678);
        segment(2'b10, 10, 1'b1, 2, 32'h0);

        do_reset(2'b10, 20);
        segment(2'b00, 10, 1'b1, 0, '0);

        for (int n = 0; n < 200; n++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do_reset(2'($urandom_range(0, 3)), 12);
            end else if (r < 3) begin
                glitch(1'($urandom_range(0, 1)), $urandom_range(1, FL - 1), 10);
            end else begin
                segment(2'($urandom_range(0, 3)), $urandom_range(LAT + 1, LAT + 8),
                        $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 5) == 0) ? $urandom_range(1, 2) : 0,
                        pick_val());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
